// File: rtl/spram_port_arbiter_if.sv
// Request/response bundle for one requester of the SPRAM arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface spram_port_arbiter_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        rvalid;
  logic [15:0] rdata;

  modport master (output valid, we, addr, wdata, be, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, be, output ready, rvalid, rdata);
endinterface

// File: rtl/spram_port_arbiter.sv
// Round-robin two-port arbiter and standby/wake sequencer in front of one
// SB_SPRAM256KA, with a fixed one-cycle read response.
module spram_port_arbiter #(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spram_port_arbiter_if.slave  a,
  spram_port_arbiter_if.slave  b,
  output logic [13:0]          ram_addr,
  output logic [15:0]          ram_din,
  output logic [3:0]           ram_maskwren,
  output logic                 ram_wren,
  output logic                 ram_cs,
  output logic                 ram_standby,
  output logic                 ram_sleep,
  output logic                 ram_poweroff,
  input  logic [15:0]          ram_dout
);

  localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {ST_ACTIVE, ST_STANDBY, ST_WAKE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [WW-1:0]   wake_q, wake_d;
  logic            last_b_q, last_b_d;
  logic [1:0]      rtag_q, rtag_d;

  logic            any_valid;
  logic            acc_a, acc_b;

  // rst_n gates the accepts so ready and RAM strobes drop the instant reset asserts.
  always_comb begin
    any_valid = a.valid | b.valid;
    acc_a = rst_n & (state_q == ST_ACTIVE) & a.valid & (~b.valid | last_b_q);
    acc_b = rst_n & (state_q == ST_ACTIVE) & b.valid & (~a.valid | ~last_b_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACTIVE;
      idle_q   <= '0;
      wake_q   <= '0;
      last_b_q <= 1'b1;
      rtag_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      wake_q   <= wake_d;
      last_b_q <= last_b_d;
      rtag_q   <= rtag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    wake_d   = wake_q;
    last_b_d = last_b_q;
    rtag_d   = {acc_b & ~b.we, acc_a & ~a.we};

    if (acc_a) begin
      last_b_d = 1'b0;
    end else if (acc_b) begin
      last_b_d = 1'b1;
    end

    unique case (state_q)
      ST_ACTIVE: begin
        // A request arriving on the very cycle the count is reached keeps us awake.
        if (any_valid) begin
          idle_d = '0;
        end else if (IDLE_CYCLES != 0) begin
          if (idle_q == IW'(IDLE_CYCLES)) begin
            state_d = ST_STANDBY;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      ST_STANDBY: begin
        if (any_valid) begin
          state_d = ST_WAKE;
          wake_d  = '0;
        end
      end
      ST_WAKE: begin
        if (wake_q == WW'(WAKE_CYCLES)) begin
          state_d = ST_ACTIVE;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    ram_cs       = acc_a | acc_b;
    ram_addr     = acc_b ? b.addr  : a.addr;
    ram_din      = acc_b ? b.wdata : a.wdata;
    ram_wren     = 1'b0;
    ram_maskwren = 4'b0000;
    if (acc_a) begin
      ram_wren     = a.we;
      ram_maskwren = a.we ? {a.be[1], a.be[1], a.be[0], a.be[0]} : 4'b0000;
    end else if (acc_b) begin
      ram_wren     = b.we;
      ram_maskwren = b.we ? {b.be[1], b.be[1], b.be[0], b.be[0]} : 4'b0000;
    end
  end

  assign a.ready      = acc_a;
  assign b.ready      = acc_b;
  assign a.rvalid     = rtag_q[0];
  assign b.rvalid     = rtag_q[1];
  assign a.rdata      = ram_dout;
  assign b.rdata      = ram_dout;
  assign ram_standby  = (state_q == ST_STANDBY);
  assign ram_sleep    = 1'b0;
  assign ram_poweroff = 1'b1;

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Randomized scoreboard bench for spram_port_arbiter with a behavioural SPRAM
// stand-in and a cycle-level reference model of the arbitration/power rules.
module tb_spram_port_arbiter;
  localparam int IDLE_C = 8;
  localparam int WAKE_C = 4;
  localparam int M_ACT = 0, M_SBY = 1, M_WAKE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spram_port_arbiter_if pa();
  spram_port_arbiter_if pb();

  logic [13:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [3:0]  ram_maskwren;
  logic        ram_wren, ram_cs, ram_standby, ram_sleep, ram_poweroff;

  spram_port_arbiter #(.IDLE_CYCLES(IDLE_C), .WAKE_CYCLES(WAKE_C)) dut (
    .clk(clk), .rst_n(rst_n), .a(pa), .b(pb),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_standby(ram_standby),
    .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff), .ram_dout(ram_dout)
  );

  // Behavioural SPRAM: nibble write mask, registered read data.
  logic [15:0] ram_mem [16384];
  logic [15:0] nib_mask;
  assign nib_mask = {{4{ram_maskwren[3]}}, {4{ram_maskwren[2]}}, {4{ram_maskwren[1]}}, {4{ram_maskwren[0]}}};
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wren) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~nib_mask) | (ram_din & nib_mask);
      else          ram_dout <= ram_mem[ram_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference model state and scoreboard
  typedef struct { bit port_b; logic [15:0] data; int due; } rsp_t;
  rsp_t q[$];
  logic [15:0] ref_mem [16384];
  int   m_mode = M_ACT;
  int   m_run = 0;
  int   act_from = 0;
  bit   m_last_b = 1'b1;

  initial begin : model
    bit ea, eb, ew;
    logic [1:0]  bw;
    logic [3:0]  em;
    logic [13:0] ad;
    logic [15:0] wd;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_mode = M_ACT; m_run = 0; m_last_b = 1'b1; q.delete();
      end else begin
        ea = 1'b0; eb = 1'b0;
        if (m_mode == M_ACT) begin
          if (pa.valid && pb.valid) begin
            if (m_last_b) ea = 1'b1; else eb = 1'b1;
          end else if (pa.valid) ea = 1'b1;
          else if (pb.valid) eb = 1'b1;
        end
        bw = ea ? pa.be : pb.be;
        ad = ea ? pa.addr : pb.addr;
        wd = ea ? pa.wdata : pb.wdata;
        ew = (ea && pa.we) || (eb && pb.we);
        em = ew ? {bw[1], bw[1], bw[0], bw[0]} : 4'b0000;
        chk("ctl{rdyA,rdyB,stby,cs,wren,mask}",
            32'({pa.ready, pb.ready, ram_standby, ram_cs, ram_wren, ram_maskwren}),
            32'({ea, eb, m_mode == M_SBY, ea | eb, ew, em}));
        if (ea || eb) begin
          chk("ram_addr", 32'(ram_addr), 32'(ad));
          if (ew) chk("ram_din", 32'(ram_din), 32'(wd));
          m_last_b = eb;
          if (ew) begin
            if (bw[0]) ref_mem[ad][7:0]  = wd[7:0];
            if (bw[1]) ref_mem[ad][15:8] = wd[15:8];
          end else begin
            r.port_b = eb; r.data = ref_mem[ad]; r.due = cyc + 1;
            q.push_back(r);
          end
        end
        case (m_mode)
          M_ACT: begin
            if (pa.valid || pb.valid) m_run = 0;
            else begin
              m_run++;
              if (IDLE_C > 0 && m_run == IDLE_C + 1) begin m_mode = M_SBY; m_run = 0; end
            end
          end
          M_SBY: if (pa.valid || pb.valid) begin m_mode = M_WAKE; act_from = cyc + WAKE_C + 2; end
          default: if (cyc + 1 >= act_from) m_mode = M_ACT;
        endcase
      end
    end
  end

  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (q.size() > 0 && q[0].due < cyc) begin
          checks++; errors++;
          $display("FAIL rvalid_missing: port_b=%0d due cycle %0d, no rvalid observed by cycle %0d", q[0].port_b, q[0].due, cyc);
          void'(q.pop_front());
        end
        if (pa.rvalid || pb.rvalid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rvalid_unexpected: got rvalid a=%0d b=%0d, none expected", pa.rvalid, pb.rvalid);
          end else begin
            r = q.pop_front();
            chk("rvalid_both", 32'(pa.rvalid & pb.rvalid), 32'(0));
            chk("rvalid_port", 32'(pb.rvalid), 32'(r.port_b));
            chk("rvalid_cycle", 32'(cyc), 32'(r.due));
            chk("rdata", 32'(pb.rvalid ? pb.rdata : pa.rdata), 32'(r.data));
          end
        end
      end
    end
  end

  task automatic do_req(input bit port_b, input bit we, input logic [13:0] addr,
                        input logic [15:0] wd, input logic [1:0] be);
    int n;
    n = 0;
    if (!port_b) begin pa.we = we; pa.addr = addr; pa.wdata = wd; pa.be = be; pa.valid = 1'b1; end
    else         begin pb.we = we; pb.addr = addr; pb.wdata = wd; pb.be = be; pb.valid = 1'b1; end
    forever begin
      @(negedge clk);
      if (port_b ? pb.ready : pa.ready) break;
      n++;
      if (n > 60) begin
        checks++; errors++;
        $display("FAIL accept_timeout: port_b=%0d addr %0h not accepted in 60 cycles", port_b, addr);
        break;
      end
    end
    @(posedge clk); #1;
    if (!port_b) pa.valid = 1'b0; else pb.valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_a_ready"}, 32'(pa.ready), 32'(0));
    chk({tag, "_b_ready"}, 32'(pb.ready), 32'(0));
    chk({tag, "_a_rvalid"}, 32'(pa.rvalid), 32'(0));
    chk({tag, "_b_rvalid"}, 32'(pb.rvalid), 32'(0));
    chk({tag, "_cs_wren_mask"}, 32'({ram_cs, ram_wren, ram_maskwren}), 32'(0));
    chk({tag, "_standby"}, 32'(ram_standby), 32'(0));
    chk({tag, "_sleep_poweroff"}, 32'({ram_sleep, ram_poweroff}), 32'(2'b01));
    chk({tag, "_rdata_pass"}, 32'(pa.rdata), 32'(ram_dout));
  endtask

  task automatic rand_port(input bit port_b);
    int g;
    for (int i = 0; i < 60; i++) begin
      g = $urandom_range(0, 9);
      repeat ((g >= 8) ? IDLE_C + 3 : g % 3) @(posedge clk);
      if (g >= 8 || g % 3 != 0) #1;
      do_req(port_b, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
             16'($urandom), 2'($urandom_range(0, 3)));
    end
  endtask

  initial begin : stimulus
    int n;
    pa.valid = 1'b0; pa.we = 1'b0; pa.addr = '0; pa.wdata = '0; pa.be = '0;
    pb.valid = 1'b0; pb.we = 1'b0; pb.addr = '0; pb.wdata = '0; pb.be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("por");
    @(posedge clk); #1; rst_n = 1'b1;

    // single port A write/read
    do_req(1'b0, 1'b1, 14'h0010, 16'h1234, 2'b11);
    do_req(1'b0, 1'b0, 14'h0010, 16'h0000, 2'b00);
    // byte enables
    do_req(1'b0, 1'b1, 14'h0005, 16'hFFFF, 2'b11);
    do_req(1'b0, 1'b1, 14'h0005, 16'hAB00, 2'b10);
    do_req(1'b0, 1'b0, 14'h0005, 16'h0000, 2'b00);
    // B write moves last grant to B so contention starts with A
    do_req(1'b1, 1'b1, 14'h0020, 16'h5A5A, 2'b11);
    fork
      begin
        do_req(1'b0, 1'b0, 14'h0010, 16'h0, 2'b00);
        do_req(1'b0, 1'b0, 14'h0005, 16'h0, 2'b00);
        do_req(1'b0, 1'b0, 14'h0020, 16'h0, 2'b00);
      end
      begin
        do_req(1'b1, 1'b0, 14'h0005, 16'h0, 2'b00);
        do_req(1'b1, 1'b0, 14'h0020, 16'h0, 2'b00);
        do_req(1'b1, 1'b0, 14'h0010, 16'h0, 2'b00);
      end
    join

    // idle into standby, then wake on B
    repeat (IDLE_C + 2) @(posedge clk);
    @(negedge clk);
    chk("standby_entry", 32'(ram_standby), 32'(1));
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 14'h0020, 16'h0, 2'b00);

    // a request arriving exactly as the idle count is reached
    n = 0;
    while (!(m_mode == M_ACT && m_run == IDLE_C) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_boundary_reached", 32'(n < 40), 32'(1));
    pa.we = 1'b0; pa.addr = 14'h0010; pa.valid = 1'b1;
    @(negedge clk);
    chk("idle_boundary_accept", 32'({pa.ready, ram_standby}), 32'(2'b10));
    @(posedge clk); #1; pa.valid = 1'b0;

    // preload the random address window, then random traffic on both ports
    for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 14'(i), 16'($urandom), 2'b11);
    fork
      rand_port(1'b0);
      rand_port(1'b1);
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_random", 32'(q.size()), 32'(0));

    // async reset during back-to-back reads
    @(posedge clk); #1;
    pa.we = 1'b0; pa.addr = 14'h0001; pa.valid = 1'b1;
    pb.we = 1'b0; pb.addr = 14'h0002; pb.valid = 1'b1;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    reset_checks("midrst");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_grant", 32'({pa.ready, pb.ready}), 32'(2'b10));
    chk("post_reset_no_rvalid", 32'({pa.rvalid, pb.rvalid}), 32'(0));
    @(posedge clk); #1; pa.valid = 1'b0;
    @(posedge clk); #1; pb.valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_final", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule
